fixed_point_seq_divider: RTL and testbench

- Multi-cycle signed fixed-point divider for Q(INT_WIDTH).(FRAC_WIDTH) operands, in the same format as alu_fixed_point: sign bit, INT_WIDTH integer bits, FRAC_WIDTH fraction bits.
- Replaces the single-cycle combinational divide path where timing cannot close. Uses a bit-serial restoring divider with valid/ready handshakes on both sides.
- Differs from the ALU on out-of-range results: it saturates and flags them instead of wrapping.

---
 rtl/fixed_point_seq_divider.sv | 141 ++++++++++++++
 tb/tb_fixed_point_seq_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_seq_divider.sv
// Bit-serial restoring divider for signed Q(INT_WIDTH).(FRAC_WIDTH) operands.
// Out-of-range quotients saturate and raise overflow/underflow; a zero divisor is flagged.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one quotient bit per clock, MSB first
// FIX   | sign, saturation and flag resolution
// DONE  | result presented until out_ready
module fixed_point_seq_divider #(
  parameter int INT_WIDTH  = 4,
  parameter int FRAC_WIDTH = 4,
  localparam int DATA_WIDTH = INT_WIDTH + FRAC_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  div_by_zero
);

  localparam int Q_BITS = DATA_WIDTH + FRAC_WIDTH;
  localparam int CW     = $clog2(Q_BITS);
  localparam logic [Q_BITS-1:0] MAX_MAG = Q_BITS'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic [Q_BITS-1:0] MIN_MAG = Q_BITS'(1 << (DATA_WIDTH-1));
  localparam logic [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state;
  logic [Q_BITS-1:0]     quo;    // dividend shifts out the top, quotient shifts in the bottom
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] dvs;
  logic                  neg;
  logic                  dz;
  logic [CW-1:0]         cnt;

  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH:0]   rem_sh, diff;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_nx;
  logic [Q_BITS-1:0]     quo_nx;

  always_comb begin
    a_mag  = a[DATA_WIDTH-1] ? DATA_WIDTH'(-a) : a;
    b_mag  = b[DATA_WIDTH-1] ? DATA_WIDTH'(-b) : b;
    rem_sh = {rem, quo[Q_BITS-1]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = rem_sh >= {1'b0, dvs};
    rem_nx = ge ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    quo_nx = {quo[Q_BITS-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      neg         <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            quo      <= {a_mag, {FRAC_WIDTH{1'b0}}};
            rem      <= '0;
            dvs      <= b_mag;
            neg      <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
            dz       <= (b == '0);
            if (b == '0) begin
              // zero divisor spends one extra cycle in FIX for a two-edge latency
              cnt   <= CW'(1);
              state <= FIX;
            end else begin
              cnt   <= CW'(Q_BITS - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state       <= DONE;
            out_valid   <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            if (dz) begin
              result      <= '0;
              div_by_zero <= 1'b1;
            end else if (neg && quo != '0) begin
              if (quo > MIN_MAG) begin
                result    <= MINV;
                underflow <= 1'b1;
              end else begin
                result <= DATA_WIDTH'(-quo[DATA_WIDTH-1:0]);
              end
            end else if (quo > MAX_MAG) begin
              result   <= MAXV;
              overflow <= 1'b1;
            end else begin
              result <= quo[DATA_WIDTH-1:0];
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_seq_divider.sv
// Self-checking bench for fixed_point_seq_divider: directed vector table,
// back-pressure, mid-operation reset and a randomized sweep against a saturating model.
module tb_fixed_point_seq_divider;

  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a, b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          overflow, underflow, div_by_zero;

  int checks = 0;
  int errors = 0;

  fixed_point_seq_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int res;
    int ov;
    int un;
    int dz;
    int lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model(input int ai, input int bi,
                                output int r, output int ov, output int un, output int dz);
    int q;
    ov = 0; un = 0; dz = 0;
    if (bi == 0) begin
      r = 0; dz = 1;
    end else begin
      q = (ai * 16) / bi;
      if (q > 255)       begin r = 255;  ov = 1; end
      else if (q < -256) begin r = -256; un = 1; end
      else r = q;
    end
  endfunction

  // Launch one operation, wait for out_valid, hold back-pressure, then hand it off.
  task automatic run_op(input int ai, input int bi, input int hold,
                        output int r, output int ov, output int un, output int dz,
                        output int lat);
    @(negedge clk);
    check("in_ready_before_op", int'(in_ready), 1);
    a = DW'(ai); b = DW'(bi); in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = DW'($urandom); b = DW'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      r = 0; ov = 0; un = 0; dz = 0;
      return;
    end
    repeat (hold) @(posedge clk);
    #1;
    r  = int'($signed(result));
    ov = int'(overflow);
    un = int'(underflow);
    dz = int'(div_by_zero);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_cleared", int'(out_valid), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int r, ov, un, dz, lat;
    int er, eov, eun, edz;
    logic [DW-1:0] held;

    vecs.push_back('{32, 16, 32, 0, 0, 0, 14});
    vecs.push_back('{16, -8, -32, 0, 0, 0, 14});
    vecs.push_back('{-5, 3, -26, 0, 0, 0, 14});
    vecs.push_back('{5, 3, 26, 0, 0, 0, 14});
    vecs.push_back('{255, 1, 255, 1, 0, 0, 14});
    vecs.push_back('{-256, 1, -256, 0, 1, 0, 14});
    vecs.push_back('{-256, -16, 255, 1, 0, 0, 14});
    vecs.push_back('{-256, 16, -256, 0, 0, 0, 14});
    vecs.push_back('{255, -1, -256, 0, 1, 0, 14});
    vecs.push_back('{-1, 100, 0, 0, 0, 0, 14});
    vecs.push_back('{-1, 16, -1, 0, 0, 0, 14});
    vecs.push_back('{0, -16, 0, 0, 0, 0, 14});
    vecs.push_back('{16, 0, 0, 0, 0, 1, 2});
    vecs.push_back('{-5, 0, 0, 0, 0, 1, 2});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_flags", int'({overflow, underflow, div_by_zero}), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, r, ov, un, dz, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_overflow", i), ov, vecs[i].ov);
      check($sformatf("vec%0d_underflow", i), un, vecs[i].un);
      check($sformatf("vec%0d_div_by_zero", i), dz, vecs[i].dz);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Back-pressure in DONE with ignored in_valid pulses.
    @(negedge clk);
    a = DW'(80); b = DW'(16); in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("bp_out_valid", int'(out_valid), 1);
    held = result;
    check("bp_result", int'($signed(held)), 80);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a = DW'(3); b = DW'(1);
      @(posedge clk);
      #1;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_result", int'(result), int'(held));
      check("bp_in_ready_low", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    repeat (16) @(posedge clk);
    #1;
    check("bp_no_queued_op", int'(out_valid), 0);

    // Reset mid-CALC after an overflowing result left nonzero outputs behind.
    run_op(255, 1, 0, r, ov, un, dz, lat);
    check("pre_rst_overflow", ov, 1);
    @(negedge clk);
    a = DW'(32); b = DW'(16); in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_flags", int'({overflow, underflow, div_by_zero}), 0);
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen = 1;
      end
      check("midrst_no_spurious", seen, 0);
    end
    run_op(32, 16, 0, r, ov, un, dz, lat);
    check("postrst_result", r, 32);
    check("postrst_latency", lat, 14);

    // Randomized sweep with back-pressure.
    for (int n = 0; n < 1000; n++) begin
      int ai, bi, fails_before;
      ai = int'($signed(DW'($urandom)));
      bi = ($urandom_range(0, 15) == 0) ? 0 : int'($signed(DW'($urandom)));
      model(ai, bi, er, eov, eun, edz);
      fails_before = errors;
      run_op(ai, bi, int'($urandom_range(0, 3)), r, ov, un, dz, lat);
      check("rand_result", r, er);
      check("rand_flags", ov * 4 + un * 2 + dz, eov * 4 + eun * 2 + edz);
      check("rand_latency", lat, (bi == 0) ? 2 : 14);
      if (errors != fails_before) $display("  operands a=%0d b=%0d", ai, bi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
